// File: rtl/adv7393_pkg.sv
// Shared types, constants and helpers for the ADV7393 line-fetch scheduler.
package adv7393_pkg;

  localparam int BUF_COUNT_DEF = 2;
  localparam int BEATS_W_DEF   = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } FetchState_t;

  // One 128-bit beat carries four pixels, so round the pixel count up to whole beats.
  function automatic logic [15:0] line_beats(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd3;
    return {1'b0, sum[16:2]};
  endfunction

endpackage

// File: rtl/adv7393_fill_cnt.sv
// Filled line-buffer counter with saturation and underrun detection.
// Defining ADV7393_UNDERRUN_CNT_EN adds a saturating underrun event counter.
module adv7393_fill_cnt #(
  parameter int BUF_COUNT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         inc,
  input  logic                         dec,
  input  logic                         clr_underrun,
  output logic [$clog2(BUF_COUNT):0]   count,
  output logic [$clog2(BUF_COUNT):0]   count_next,
  output logic                         underrun
`ifdef ADV7393_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt
`endif
);

  localparam int CW = $clog2(BUF_COUNT) + 1;

  logic underrun_hit;

  // A release that meets an empty ring is an underrun and leaves the count at zero.
  always_comb begin
    count_next   = count;
    underrun_hit = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (inc && !dec) begin
      if (count < CW'(BUF_COUNT))
        count_next = count + CW'(1);
    end else if (dec && !inc) begin
      if (count == '0)
        underrun_hit = 1'b1;
      else
        count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      count <= count_next;
      if (underrun_hit)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;
    end
  end

`ifdef ADV7393_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underrun_cnt <= '0;
    else if (underrun_hit && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: rtl/adv7393_fetch_sched.sv
// Line-fetch scheduler: one AXI read burst per active line into a ring of line buffers.
// Defining ADV7393_UNDERRUN_CNT_EN adds the underrun_cnt_o event counter output.
module adv7393_fetch_sched
  import adv7393_pkg::*;
#(
  parameter int M_AXI_DWIDTH = 128,
  parameter int AWIDTH       = 32,
  parameter int BUF_COUNT    = BUF_COUNT_DEF,
  parameter int LINES_W      = 10,
  parameter int BEATS_W      = BEATS_W_DEF
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AWIDTH-1:0]            cfg_base_i,
  input  logic [AWIDTH-1:0]            cfg_line_step_i,
  input  logic [AWIDTH-1:0]            cfg_frame_stride_i,
  input  logic [2:0]                   cfg_count_i,
  input  logic [15:0]                  cfg_line_len_i,
  input  logic [LINES_W-1:0]           cfg_lines_i,
  input  logic                         frame_start_i,
  input  logic                         field_i,
  input  logic                         frame_adv_i,
  input  logic                         line_done_i,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic [AWIDTH-1:0]            req_addr_o,
  output logic [BEATS_W-1:0]           req_beats_o,
  output logic [$clog2(BUF_COUNT)-1:0] req_buf_o,
  input  logic                         fetch_done_i,
  output logic [$clog2(BUF_COUNT):0]   filled_o,
  output logic                         busy_o,
  output logic                         underrun_o
`ifdef ADV7393_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt_o
`endif
);

  localparam int BW = $clog2(BUF_COUNT);
  localparam int CW = BW + 1;

  if (M_AXI_DWIDTH != 128 || BUF_COUNT < 2 || BUF_COUNT > 8 ||
      (BUF_COUNT & (BUF_COUNT - 1)) != 0) begin : g_param_check
    $error("adv7393_fetch_sched: unsupported M_AXI_DWIDTH or BUF_COUNT");
  end

  FetchState_t       state;
  logic [AWIDTH-1:0] frame_base, step_r, cur_base, new_base, start_addr;
  logic [2:0]        frame_ptr, new_ptr;
  logic [LINES_W:0]  line_r, next_line;
  logic [LINES_W-1:0] lines_r;
  logic              base_loaded, adv_pending, restart_pending, restart_field;
  logic              start_idle, apply_start, start_field, rotate, room, fill_inc;
  logic [CW-1:0]     fill_next;

  // A field start arriving mid-request is deferred until that request's done pulse.
  always_comb begin
    start_idle  = frame_start_i &&
                  (state == ST_IDLE || (state == ST_ISSUE && !req_valid_o));
    apply_start = start_idle ||
                  (state == ST_WAIT && fetch_done_i && (restart_pending || frame_start_i));
    start_field = frame_start_i ? field_i : restart_field;
    fill_inc    = state == ST_WAIT && fetch_done_i && !restart_pending && !frame_start_i;
    room        = fill_next < CW'(BUF_COUNT);
    next_line   = line_r + (LINES_W + 1)'(2);

    cur_base = base_loaded ? frame_base : cfg_base_i;
    rotate   = apply_start && !start_field && adv_pending;
    new_base = cur_base;
    new_ptr  = frame_ptr;
    if (rotate) begin
      if (frame_ptr >= cfg_count_i - 3'd1) begin
        new_ptr  = '0;
        new_base = cfg_base_i;
      end else begin
        new_ptr  = frame_ptr + 3'd1;
        new_base = cur_base + cfg_frame_stride_i;
      end
    end
    start_addr = new_base + (start_field ? cfg_line_step_i : '0);
  end

  adv7393_fill_cnt #(
    .BUF_COUNT(BUF_COUNT)
  ) u_fill (
    .clk          (aclk),
    .rst_n        (aresetn),
    .clear        (apply_start),
    .inc          (fill_inc),
    .dec          (line_done_i),
    .clr_underrun (frame_start_i),
    .count        (filled_o),
    .count_next   (fill_next),
    .underrun     (underrun_o)
`ifdef ADV7393_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt_o)
`endif
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= ST_IDLE;
      busy_o          <= 1'b0;
      req_valid_o     <= 1'b0;
      req_addr_o      <= '0;
      req_beats_o     <= '0;
      req_buf_o       <= '0;
      frame_base      <= '0;
      frame_ptr       <= '0;
      base_loaded     <= 1'b0;
      adv_pending     <= 1'b0;
      restart_pending <= 1'b0;
      restart_field   <= 1'b0;
      line_r          <= '0;
      lines_r         <= '0;
      step_r          <= '0;
    end else begin
      base_loaded <= 1'b1;
      if (!base_loaded)
        frame_base <= cfg_base_i;

      if (rotate)
        adv_pending <= frame_adv_i;
      else if (frame_adv_i)
        adv_pending <= 1'b1;

      if (apply_start) begin
        restart_pending <= 1'b0;
      end else if (frame_start_i) begin
        restart_pending <= 1'b1;
        restart_field   <= field_i;
      end

      if (apply_start) begin
        state       <= ST_ISSUE;
        busy_o      <= 1'b1;
        req_valid_o <= room;
        frame_base  <= new_base;
        frame_ptr   <= new_ptr;
        line_r      <= {{LINES_W{1'b0}}, start_field};
        lines_r     <= cfg_lines_i;
        step_r      <= cfg_line_step_i;
        req_addr_o  <= start_addr;
        req_beats_o <= BEATS_W'(line_beats(cfg_line_len_i));
        req_buf_o   <= '0;
      end else begin
        case (state)
          ST_ISSUE: begin
            if (!req_valid_o) begin
              req_valid_o <= room;
            end else if (req_ready_i) begin
              req_valid_o <= 1'b0;
              state       <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (fetch_done_i) begin
              req_buf_o  <= req_buf_o + BW'(1);
              line_r     <= next_line;
              req_addr_o <= req_addr_o + {step_r[AWIDTH-2:0], 1'b0};
              if (next_line >= {1'b0, lines_r}) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end else begin
                state       <= ST_ISSUE;
                req_valid_o <= room;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
